// File: rtl/sr_flag_bank_pkg.sv
// ---------------------------------------------------------------------------
// sr_flag_bank_pkg
// Shared definitions for the set/reset flag bank.
//   POLICY_*      : conflict-resolution codes used when set and reset are both
//                   active on the same channel in the same cycle.
//   resolve_next  : next flag value from current value and gated set/reset,
//                   excluding the reset and clr_all overrides.
// ---------------------------------------------------------------------------
package sr_flag_bank_pkg;

  localparam int POLICY_HOLD   = 0;
  localparam int POLICY_SET    = 1;
  localparam int POLICY_RESET  = 2;
  localparam int POLICY_TOGGLE = 3;

  function automatic logic resolve_next(input logic q_cur,
                                        input logic se,
                                        input logic re,
                                        input int   policy);
    logic nxt;
    nxt = q_cur;
    if (se && !re) begin
      nxt = 1'b1;
    end else if (re && !se) begin
      nxt = 1'b0;
    end else if (se && re) begin
      case (policy)
        POLICY_SET:    nxt = 1'b1;
        POLICY_RESET:  nxt = 1'b0;
        POLICY_TOGGLE: nxt = ~q_cur;
        default:       nxt = q_cur;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sr_flag_bank_cell.sv
// ---------------------------------------------------------------------------
// sr_flag_cell
// One flag channel: s/r synchronisers, polarity normalisation, optional
// rising-edge gating, next-state resolution, sticky conflict and rise-event
// flags, and the q/qn register.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   s, r          : raw set/reset requests (polarity per ACTIVE_LOW)
//   clr_all       : synchronous clear of q
//   conflict_clr  : write-1-to-clear for conflict
//   evt_clr       : write-1-to-clear for evt
//   q, qn         : flag state and its complement
//   conflict      : sticky, set and reset were both active
//   evt           : sticky, q rose 0->1
// ---------------------------------------------------------------------------
module sr_flag_cell
  import sr_flag_bank_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int EDGE_MODE       = 0,
  parameter int CONFLICT_POLICY = POLICY_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  input  logic clr_all,
  input  logic conflict_clr,
  input  logic evt_clr,
  output logic q,
  output logic qn,
  output logic conflict,
  output logic evt
);

  // Raw level that means "not requesting"; also the XOR mask that turns a raw
  // level into an active-high request.
  localparam logic INACTIVE = (ACTIVE_LOW != 0);

  logic s_sync;
  logic r_sync;
  logic sa;
  logic ra;
  logic se;
  logic re;
  logic q_nxt;
  logic rise;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] s_pipe;
      logic [SYNC_STAGES-1:0] r_pipe;

      // NOTE: synchroniser flops are reset to the inactive level, not left
      // unreset, so the first cycles after reset cannot look like a request
      // or produce a false edge in edge mode.
      always_ff @(posedge clk) begin
        if (reset) begin
          s_pipe <= {SYNC_STAGES{INACTIVE}};
          r_pipe <= {SYNC_STAGES{INACTIVE}};
        end else begin
          s_pipe[0] <= s;
          r_pipe[0] <= r;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            s_pipe[i] <= s_pipe[i-1];
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign s_sync = s_pipe[SYNC_STAGES-1];
      assign r_sync = r_pipe[SYNC_STAGES-1];
    end else begin : g_bypass
      assign s_sync = s;
      assign r_sync = r;
    end
  endgenerate

  assign sa = s_sync ^ INACTIVE;
  assign ra = r_sync ^ INACTIVE;

  generate
    if (EDGE_MODE != 0) begin : g_edge
      // History holds the previous synchronised raw level.
      logic s_hist;
      logic r_hist;

      always_ff @(posedge clk) begin
        if (reset) begin
          s_hist <= INACTIVE;
          r_hist <= INACTIVE;
        end else begin
          s_hist <= s_sync;
          r_hist <= r_sync;
        end
      end

      assign se = sa & ~(s_hist ^ INACTIVE);
      assign re = ra & ~(r_hist ^ INACTIVE);
    end else begin : g_level
      assign se = sa;
      assign re = ra;
    end
  endgenerate

  // NOTE: every output of this block is assigned on every path (default
  // first), so no latch is inferred.
  always_comb begin
    q_nxt = 1'b0;
    if (!clr_all) begin
      q_nxt = resolve_next(q, se, re, CONFLICT_POLICY);
    end
    rise = q_nxt & ~q;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= 1'b0;
      conflict <= 1'b0;
      evt      <= 1'b0;
    end else begin
      q        <= q_nxt;
      // Set terms are ORed in last so a same-cycle set beats the clear.
      conflict <= (se & re) | (conflict & ~conflict_clr);
      evt      <= rise | (evt & ~evt_clr);
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/sr_flag_bank.sv
// ---------------------------------------------------------------------------
// sr_flag_bank
// Bank of CHANNELS independent clocked set/reset flags with synchronised
// inputs, selectable polarity, level/edge triggering and a conflict policy.
// Sticky rise events feed one registered, per-channel maskable interrupt.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   s, r          : per-channel set/reset requests
//   clr_all       : synchronous clear of all q bits (evt/conflict untouched)
//   q, qn         : flag state and complement
//   conflict      : sticky set+reset indication, conflict_clr is W1C
//   evt           : sticky 0->1 indication of q, evt_clr is W1C
//   irq_en        : per-channel interrupt enable
//   irq           : registered OR of (evt & irq_en)
// ---------------------------------------------------------------------------
module sr_flag_bank
  import sr_flag_bank_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int EDGE_MODE       = 0,
  parameter int CONFLICT_POLICY = POLICY_HOLD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] r,
  input  logic                clr_all,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] qn,
  output logic [CHANNELS-1:0] conflict,
  input  logic [CHANNELS-1:0] conflict_clr,
  output logic [CHANNELS-1:0] evt,
  input  logic [CHANNELS-1:0] evt_clr,
  input  logic [CHANNELS-1:0] irq_en,
  output logic                irq
);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      sr_flag_cell #(
        .SYNC_STAGES    (SYNC_STAGES),
        .ACTIVE_LOW     (ACTIVE_LOW),
        .EDGE_MODE      (EDGE_MODE),
        .CONFLICT_POLICY(CONFLICT_POLICY)
      ) u_cell (
        .clk         (clk),
        .reset       (reset),
        .s           (s[i]),
        .r           (r[i]),
        .clr_all     (clr_all),
        .conflict_clr(conflict_clr[i]),
        .evt_clr     (evt_clr[i]),
        .q           (q[i]),
        .qn          (qn[i]),
        .conflict    (conflict[i]),
        .evt         (evt[i])
      );
    end
  endgenerate

  // Registered from the current evt, so irq trails evt by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(evt & irq_en);
    end
  end

endmodule

// File: tb/tb_sr_flag_bank.sv
// ---------------------------------------------------------------------------
// tb_sr_flag_bank
// Directed bench for sr_flag_bank. Group A: four level-mode instances, one per
// conflict policy, plus one edge-mode instance, all CHANNELS=4, SYNC_STAGES=2,
// ACTIVE_LOW=1 and sharing inputs. Group B: one SYNC_STAGES=0, ACTIVE_LOW=1'b0
// instance. Inputs change 1 time unit after a rising edge; outputs are sampled
// at the same point, so "edge k" means the k-th rising edge after a drive.
// ---------------------------------------------------------------------------
module tb_sr_flag_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Group A shared inputs
  logic       reset_a;
  logic [3:0] s_a, r_a, conflict_clr_a, evt_clr_a, irq_en_a;
  logic       clr_all_a;

  // Level instances, index = conflict policy
  logic [3:0] q_a [4];
  logic [3:0] qn_a [4];
  logic [3:0] conflict_a [4];
  logic [3:0] evt_a [4];
  logic       irq_a [4];

  generate
    for (genvar p = 0; p < 4; p++) begin : g_pol
      sr_flag_bank #(
        .CHANNELS(4), .SYNC_STAGES(2), .ACTIVE_LOW(1), .EDGE_MODE(0),
        .CONFLICT_POLICY(p)
      ) u_dut (
        .clk(clk), .reset(reset_a), .s(s_a), .r(r_a), .clr_all(clr_all_a),
        .q(q_a[p]), .qn(qn_a[p]), .conflict(conflict_a[p]),
        .conflict_clr(conflict_clr_a), .evt(evt_a[p]), .evt_clr(evt_clr_a),
        .irq_en(irq_en_a), .irq(irq_a[p])
      );
    end
  endgenerate

  // Edge-mode instance
  logic [3:0] q_e, qn_e, conflict_e, evt_e;
  logic       irq_e;

  sr_flag_bank #(
    .CHANNELS(4), .SYNC_STAGES(2), .ACTIVE_LOW(1), .EDGE_MODE(1),
    .CONFLICT_POLICY(0)
  ) u_edge (
    .clk(clk), .reset(reset_a), .s(s_a), .r(r_a), .clr_all(clr_all_a),
    .q(q_e), .qn(qn_e), .conflict(conflict_e),
    .conflict_clr(conflict_clr_a), .evt(evt_e), .evt_clr(evt_clr_a),
    .irq_en(irq_en_a), .irq(irq_e)
  );

  // Group B: unsynchronised, active-high inputs
  logic       reset_b;
  logic [3:0] s_b, r_b, irq_en_b;
  logic       clr_all_b;
  logic [3:0] conflict_clr_b, evt_clr_b;
  logic [3:0] q_f, qn_f, conflict_f, evt_f;
  logic       irq_f;

  sr_flag_bank #(
    .CHANNELS(4), .SYNC_STAGES(0), .ACTIVE_LOW(0), .EDGE_MODE(0),
    .CONFLICT_POLICY(0)
  ) u_fast (
    .clk(clk), .reset(reset_b), .s(s_b), .r(r_b), .clr_all(clr_all_b),
    .q(q_f), .qn(qn_f), .conflict(conflict_f),
    .conflict_clr(conflict_clr_b), .evt(evt_f), .evt_clr(evt_clr_b),
    .irq_en(irq_en_b), .irq(irq_f)
  );

  // Expected q[1] per policy for conflict edges 3..6 (bit k-3)
  logic [3:0] exp_run1 [4];
  logic [3:0] exp_run2 [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Prior q[1]=0: hold, set, reset, toggle(1,0,1,0)
    exp_run1[0] = 4'b0000; exp_run1[1] = 4'b1111;
    exp_run1[2] = 4'b0000; exp_run1[3] = 4'b0101;
    // Prior q[1]=1: hold, set, reset, toggle(0,1,0,1)
    exp_run2[0] = 4'b1111; exp_run2[1] = 4'b1111;
    exp_run2[2] = 4'b0000; exp_run2[3] = 4'b1010;

    reset_a = 1'b1; s_a = 4'hF; r_a = 4'hF; clr_all_a = 1'b0;
    conflict_clr_a = 4'h0; evt_clr_a = 4'h0; irq_en_a = 4'h0;
    reset_b = 1'b1; s_b = 4'h0; r_b = 4'h0; irq_en_b = 4'hF;
    clr_all_b = 1'b0; conflict_clr_b = 4'h0; evt_clr_b = 4'h0;

    // ---- Reset with inactive inputs, then 10 quiet cycles ----
    repeat (3) tick();
    reset_a = 1'b0; reset_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_q",      q_a[0],      4'h0);
      check("rst_qn",     qn_a[0],     4'hF);
      check("rst_evt",    evt_a[0],    4'h0);
      check("rst_irq",    irq_a[0],    1'b0);
      check("rst_edge_q", q_e,         4'h0);
      check("rst_edge_evt", evt_e,     4'h0);
      check("rst_fast_q", q_f,         4'h0);
    end

    // ---- Set ch0: latency 3 edges, evt, irq, evt_clr ----
    irq_en_a = 4'h1;
    s_a = 4'hE;
    tick(); check("set0_e1_q", q_a[0][0], 1'b0);
    tick(); check("set0_e2_q", q_a[0][0], 1'b0);
    tick();
    check("set0_e3_q",   q_a[0][0],  1'b1);
    check("set0_e3_qn",  qn_a[0][0], 1'b0);
    check("set0_e3_evt", evt_a[0][0], 1'b1);
    check("set0_e3_irq", irq_a[0],   1'b0);
    s_a = 4'hF;
    tick();
    check("set0_e4_irq", irq_a[0],  1'b1);
    check("set0_e4_q",   q_a[0][0], 1'b1);
    evt_clr_a = 4'h1;
    tick();
    evt_clr_a = 4'h0;
    check("evtclr_evt", evt_a[0][0], 1'b0);
    check("evtclr_irq_lag", irq_a[0], 1'b1);
    tick();
    check("evtclr_irq", irq_a[0], 1'b0);

    // ---- Conflict on ch1, prior q[1]=0, both held 4 cycles ----
    s_a = 4'hD; r_a = 4'hD;
    tick();
    tick();
    check("run1_e2_set_q", q_a[1][1], 1'b0);
    for (int k = 3; k <= 6; k++) begin
      tick();
      if (k == 4) begin
        s_a = 4'hF; r_a = 4'hF;
      end
      for (int p = 0; p < 4; p++) begin
        check($sformatf("run1_p%0d_e%0d_q", p, k), q_a[p][1], exp_run1[p][k-3]);
      end
    end
    for (int p = 0; p < 4; p++) begin
      check($sformatf("run1_p%0d_conflict", p), conflict_a[p][1], 1'b1);
    end
    tick();
    check("run1_toggle_stops", q_a[3][1], 1'b0);
    tick();

    // ---- Set q[1]=1 everywhere, then conflict with prior 1 ----
    s_a = 4'hD;
    tick();
    s_a = 4'hF;
    tick();
    tick();
    for (int p = 0; p < 4; p++) begin
      check($sformatf("pre2_p%0d_q", p), q_a[p][1], 1'b1);
    end
    tick(); tick();
    s_a = 4'hD; r_a = 4'hD;
    tick(); tick();
    for (int k = 3; k <= 6; k++) begin
      tick();
      if (k == 4) begin
        s_a = 4'hF; r_a = 4'hF;
      end
      for (int p = 0; p < 4; p++) begin
        check($sformatf("run2_p%0d_e%0d_q", p, k), q_a[p][1], exp_run2[p][k-3]);
      end
    end
    tick(); tick();
    conflict_clr_a = 4'h2;
    tick();
    conflict_clr_a = 4'h0;
    for (int p = 0; p < 4; p++) begin
      check($sformatf("cclr_p%0d", p), conflict_a[p][1], 1'b0);
    end
    check("p0_evt_before_clr_all", evt_a[0], 4'h2);

    // ---- conflict_clr in the same cycle as a new conflict ----
    s_a = 4'hD; r_a = 4'hD;
    tick();
    s_a = 4'hF; r_a = 4'hF;
    tick();
    conflict_clr_a = 4'h2;
    tick();
    check("setwins_conflict", conflict_a[0][1], 1'b1);
    check("setwins_hold_q",   q_a[0][1],        1'b1);
    tick();
    conflict_clr_a = 4'h0;
    check("cclr_after_setwins", conflict_a[0][1], 1'b0);
    tick(); tick();

    // ---- clr_all overrides an active set on ch3 ----
    s_a = 4'h7; clr_all_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("clrall_e%0d_q", k), q_a[0], 4'h0);
      check($sformatf("clrall_e%0d_qn", k), qn_a[0], 4'hF);
    end
    check("clrall_keeps_evt", evt_a[0], 4'h2);
    clr_all_a = 1'b0;
    tick();
    check("clrall_drop_q",   q_a[0],   4'h8);
    check("clrall_drop_evt", evt_a[0], 4'hA);
    check("irq_masked",      irq_a[0], 1'b0);
    s_a = 4'hF;
    tick(); tick(); tick();

    // ---- Edge mode: s[2] held low, r[2] pulsed while s still low ----
    s_a = 4'hB;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 2) check("edge_e2_q", q_e[2], 1'b0);
      if (k == 3) begin
        check("edge_e3_q",   q_e[2],   1'b1);
        check("edge_e3_evt", evt_e[2], 1'b1);
      end
      if (k == 7) check("edge_e7_q", q_e[2], 1'b1);
      if (k == 8) begin
        check("edge_e8_q",        q_e[2],           1'b0);
        check("level_e8_q",       q_a[0][2],        1'b1);
        check("level_e8_conflict", conflict_a[0][2], 1'b1);
      end
      if (k == 9) check("edge_no_conflict", conflict_e[2], 1'b0);
      if (k == 5) r_a = 4'hB;
      if (k == 6) r_a = 4'hF;
      if (k == 7) s_a = 4'hF;
    end
    tick(); tick(); tick();

    // ---- Mid-operation reset on group A with a pending set ----
    irq_en_a = 4'hF;
    tick();
    check("pre_reset_irq", irq_a[0], 1'b1);
    reset_a = 1'b1; s_a = 4'h0;
    tick();
    reset_a = 1'b0; s_a = 4'hF;
    check("midrst_q",        q_a[0],        4'h0);
    check("midrst_qn",       qn_a[0],       4'hF);
    check("midrst_evt",      evt_a[0],      4'h0);
    check("midrst_conflict", conflict_a[0], 4'h0);
    check("midrst_irq",      irq_a[0],      1'b0);
    repeat (4) tick();
    check("midrst_discard_q",   q_a[0], 4'h0);
    check("midrst_discard_evt", evt_e,  4'h0);

    // ---- Group B: bypassed sync, active-high inputs ----
    s_b = 4'h1;
    tick();
    s_b = 4'h0;
    check("fast_set_q",   q_f,   4'h1);
    check("fast_set_qn",  qn_f,  4'hE);
    check("fast_set_evt", evt_f, 4'h1);
    tick();
    check("fast_irq", irq_f, 1'b1);
    r_b = 4'h1;
    tick();
    r_b = 4'h0;
    check("fast_reset_q", q_f, 4'h0);
    s_b = 4'h6;
    tick();
    s_b = 4'h0;
    check("fast_multi_q", q_f, 4'h6);
    s_b = 4'h8; r_b = 4'h8;
    tick();
    s_b = 4'h0; r_b = 4'h0;
    check("fast_conflict",   conflict_f, 4'h8);
    check("fast_conflict_q", q_f,        4'h6);
    reset_b = 1'b1; s_b = 4'h1;
    tick();
    reset_b = 1'b0; s_b = 4'h0;
    check("fast_rst_q",        q_f,        4'h0);
    check("fast_rst_qn",       qn_f,       4'hF);
    check("fast_rst_conflict", conflict_f, 4'h0);
    check("fast_rst_evt",      evt_f,      4'h0);
    check("fast_rst_irq",      irq_f,      1'b0);
    tick();
    check("fast_rst_discard_q", q_f, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
